// File: rtl/uart_rx_os_if.sv
// uart_rx_os_if -- receive-side handshake bundle of the oversampling UART receiver.
//   rx_data   : received word, meaningful while rx_valid=1
//   rx_valid  : holding register contains unread data
//   rx_ready  : consumer accepts rx_data when rx_valid & rx_ready
//   frame_err : one-clk strobe, stop bit sampled low
//   overrun   : one-clk strobe, good frame dropped because holding register was full
//   par_err   : one-clk strobe, parity mismatch (constant 0 without parity support)
// Modports: master = receiver side, slave = consumer side.
interface uart_rx_os_if #(
  parameter int data_bits = 8
);
  logic [data_bits-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 par_err;

  modport master (
    output rx_data, rx_valid, frame_err, overrun, par_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, overrun, par_err,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_os.sv
// uart_rx_os -- oversampling UART receiver with a one-word holding register.
// Samples the serial line on os_tick strobes (os_rate per bit), finds the start
// bit mid-point and takes each following bit at whole bit periods after it.
// Ports:
//   clk      : single clock, rising edge
//   rst      : synchronous, active-high reset
//   os_tick  : one-clk strobe at os_rate x baud
//   rxd      : asynchronous serial input, idle high
//   rx_if    : uart_rx_os_if.master (rx_data/rx_valid/rx_ready, frame_err, overrun, par_err)
// Parameters: data_bits (5..9, LSB first), os_rate (even, >= 4).
// Optional feature: define UART_RX_PARITY_EN for one even-parity bit after the data.
module uart_rx_os #(
  parameter int data_bits = 8,
  parameter int os_rate   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         os_tick,
  input  logic         rxd,
  uart_rx_os_if.master rx_if
);

  localparam int CNT_W = $clog2(os_rate);
  localparam int BIT_W = $clog2(data_bits);
  localparam logic [CNT_W-1:0] HALF_TICK = CNT_W'(os_rate / 2);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(os_rate - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(data_bits - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  // synchronizer stages and their fill flags
  logic rxd_p0, rxd_p1;
  logic vld_p0, vld_p1;
  logic rxs;
  // set once a real high level has been seen after reset; a start edge needs it
  logic armed_q;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [data_bits-1:0] shift_q, shift_d;
  logic                 frame_good, frame_bad;

  logic [data_bits-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 overrun_q;

`ifdef UART_RX_PARITY_EN
  logic                 par_fail_q, par_fail_d;
  logic                 par_bad;
  logic                 par_err_q;
`endif

  assign rxs = rxd_p1;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_fail_d = par_fail_q;
    par_bad    = 1'b0;
`endif
    if (os_tick) begin
      case (state_q)
        IDLE: begin
          // this tick is sample 0 of the start bit, so the next one is sample 1
          if (armed_q && !rxs) begin
            state_d    = START;
            tick_cnt_d = CNT_W'(1);
          end
        end
        START: begin
          if (tick_cnt_q == HALF_TICK) begin
            if (rxs) begin
              state_d = IDLE;
            end else begin
              state_d    = DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
`ifdef UART_RX_PARITY_EN
              par_fail_d = 1'b0;
`endif
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            shift_d    = {rxs, shift_q[data_bits-1:1]};
            if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            // even parity: data bits plus parity bit must XOR to 0
            par_fail_d = rxs ^ (^shift_q);
            state_d    = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            if (rxs) begin
              state_d = IDLE;
`ifdef UART_RX_PARITY_EN
              frame_good = !par_fail_q;
              par_bad    = par_fail_q;
`else
              frame_good = 1'b1;
`endif
            end else begin
              // frame error wins over a parity error on the same frame
              frame_bad = 1'b1;
              state_d   = BREAK;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        BREAK: begin
          if (rxs) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_p0      <= 1'b1;
      rxd_p1      <= 1'b1;
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_fail_q  <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      // stage 0 -> stage 1: metastability filter on the raw line
      rxd_p0 <= rxd;
      vld_p0 <= 1'b1;
      rxd_p1 <= rxd_p0;
      vld_p1 <= vld_p0;
      // the reset value of the synchronizer is not a real line level
      if (vld_p1 && rxs) armed_q <= 1'b1;

      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;

      frame_err_q <= frame_bad;
      overrun_q   <= frame_good && rx_valid_q && !rx_if.rx_ready;
`ifdef UART_RX_PARITY_EN
      par_fail_q  <= par_fail_d;
      par_err_q   <= par_bad;
`endif
      // holding register: a read in the same clock frees it for the new word
      if (frame_good && (!rx_valid_q || rx_if.rx_ready)) begin
        rx_data_q  <= shift_q;
        rx_valid_q <= 1'b1;
      end else if (rx_valid_q && rx_if.rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign rx_if.rx_data   = rx_data_q;
  assign rx_if.rx_valid  = rx_valid_q;
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign rx_if.par_err   = par_err_q;
`else
  assign rx_if.par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os -- self-checking bench for uart_rx_os (data_bits=8, os_rate=4,
// os_tick every 4 clocks). Frames come from a vector table plus hand-written
// sequences; expected words go into a scoreboard queue and are popped when the
// receiver hands a word over.
module tb_uart_rx_os;
  localparam int DB       = 8;
  localparam int OS       = 4;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = OS * TICK_DIV;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // clocks from the tick after the falling edge is driven to the stop-sample tick:
  // 1 tick to detect, OS/2 to the mid-point, then data/parity/stop at OS each
  localparam int STOP_LAT = TICK_DIV * (1 + OS / 2 + (DB + PAR + 1) * OS);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic os_tick = 1'b0;
  logic rxd = 1'b1;

  uart_rx_os_if #(.data_bits(DB)) rx_if ();

  uart_rx_os #(.data_bits(DB), .os_rate(OS)) dut (
    .clk    (clk),
    .rst    (rst),
    .os_tick(os_tick),
    .rxd    (rxd),
    .rx_if  (rx_if)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int ph = 0;
  bit was_tick = 1'b0;
  int edge_cyc = 0;
  int rise_cyc = -1;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  logic [DB-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
  endtask

  // advance one clock; inputs change 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
    was_tick = os_tick;
    cyc++;
    os_tick = (ph == 0);
    ph = (ph + 1) % TICK_DIV;
  endtask

  task automatic align();
    while (!was_tick) step();
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (BIT_CLKS) step();
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic par_good);
    align();
    edge_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    if (PAR != 0) send_bit((^d) ^ !par_good);
    send_bit(stop);
    rxd = 1'b1;
  endtask

  task automatic idle(input int nbits);
    rxd = 1'b1;
    repeat (nbits * BIT_CLKS) step();
  endtask

  // output monitor, sampled on the falling edge
  logic prev_valid = 1'b0;
  logic prev_acc = 1'b0;
  logic [DB-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (rx_if.rx_valid === 1'b1 && !prev_valid) rise_cyc = cyc;
    if (prev_valid && !prev_acc && rx_if.rx_valid === 1'b1)
      chk("hold_stable", 32'(rx_if.rx_data), 32'(prev_data));
    if (rx_if.rx_valid === 1'b1 && rx_if.rx_ready === 1'b1) begin
      if (exp_q.size() == 0) chk("rx_data_unexpected", 32'(rx_if.rx_data), 32'hFFFF_FFFF);
      else chk("rx_data", 32'(rx_if.rx_data), 32'(exp_q.pop_front()));
    end
    if (rx_if.frame_err === 1'b1) fe_cnt++;
    if (rx_if.overrun === 1'b1) ov_cnt++;
    if (rx_if.par_err === 1'b1) pe_cnt++;
    prev_valid = (rx_if.rx_valid === 1'b1);
    prev_acc   = (rx_if.rx_valid === 1'b1) && (rx_if.rx_ready === 1'b1);
    prev_data  = rx_if.rx_data;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_word;
    int         exp_fe;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int fe0, ov0, pe0;
    vecs[0] = '{8'h55, 1'b1, 1'b1, 0};
    vecs[1] = '{8'hA3, 1'b0, 1'b0, 1};
    vecs[2] = '{8'h12, 1'b1, 1'b1, 0};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 0};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 0};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 0};

    // reset state
    rx_if.rx_ready = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    chk("rst_rx_valid", 32'(rx_if.rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_if.rx_data), 32'd0);
    chk("rst_frame_err", 32'(rx_if.frame_err), 32'd0);
    chk("rst_overrun", 32'(rx_if.overrun), 32'd0);
    chk("rst_par_err", 32'(rx_if.par_err), 32'd0);
    rst = 1'b0;
    idle(1);

    // table-driven frames, consumer always ready
    rx_if.rx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
      rise_cyc = -1;
      if (vecs[i].exp_word) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop, 1'b1);
      idle(2);
      chk($sformatf("v%0d_frame_err", i), 32'(fe_cnt - fe0), 32'(vecs[i].exp_fe));
      chk($sformatf("v%0d_overrun", i), 32'(ov_cnt - ov0), 32'd0);
      chk($sformatf("v%0d_par_err", i), 32'(pe_cnt - pe0), 32'd0);
      chk($sformatf("v%0d_latency", i), 32'((rise_cyc < 0) ? -1 : rise_cyc - edge_cyc),
          32'(vecs[i].exp_word ? STOP_LAT : -1));
      chk($sformatf("v%0d_pending", i), 32'(exp_q.size()), 32'd0);
    end

    // one-tick glitch on the line is rejected, receiver goes back to idle
    fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
    rise_cyc = -1;
    align();
    rxd = 1'b0;
    repeat (TICK_DIV) step();
    rxd = 1'b1;
    idle(2);
    chk("glitch_valid", 32'(rise_cyc), 32'hFFFF_FFFF);
    chk("glitch_strobes", 32'((fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0)), 32'd0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b1);
    idle(2);
    chk("glitch_next_frame", 32'(exp_q.size()), 32'd0);

    // overrun: second word dropped while the first is unread
    rx_if.rx_ready = 1'b0;
    ov0 = ov_cnt;
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, 1'b1);
    idle(1);
    send_frame(8'h02, 1'b1, 1'b1);
    idle(2);
    chk("ovr_pulses", 32'(ov_cnt - ov0), 32'd1);
    chk("ovr_valid_held", 32'(rx_if.rx_valid), 32'd1);
    chk("ovr_data_held", 32'(rx_if.rx_data), 32'h01);
    rx_if.rx_ready = 1'b1;
    step();
    step();
    chk("ovr_valid_cleared", 32'(rx_if.rx_valid), 32'd0);
    chk("ovr_pending", 32'(exp_q.size()), 32'd0);

    // reset in the middle of the data bits of 0xFF, with a word still held
    rx_if.rx_ready = 1'b0;
    exp_q.push_back(8'h99);
    send_frame(8'h99, 1'b1, 1'b1);
    idle(1);
    align();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    rst = 1'b1;
    step();
    step();
    chk("midrst_rx_valid", 32'(rx_if.rx_valid), 32'd0);
    chk("midrst_rx_data", 32'(rx_if.rx_data), 32'd0);
    chk("midrst_strobes", 32'({rx_if.frame_err, rx_if.overrun, rx_if.par_err}), 32'd0);
    exp_q.delete();
    rst = 1'b0;
    rx_if.rx_ready = 1'b1;
    rise_cyc = -1;
    for (int i = 0; i < 5 + PAR; i++) send_bit(1'b1);
    send_bit(1'b1);
    idle(2);
    chk("midrst_no_partial", 32'(rise_cyc), 32'hFFFF_FFFF);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(2);
    chk("midrst_next_frame", 32'(exp_q.size()), 32'd0);

    // reset while the line is low: no start until a fresh falling edge
    fe0 = fe_cnt;
    align();
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    rise_cyc = -1;
    for (int i = 0; i < 6 + PAR; i++) send_bit(1'b0);
    send_bit(1'b1);
    idle(2);
    chk("lowrst_no_word", 32'(rise_cyc), 32'hFFFF_FFFF);
    chk("lowrst_frame_err", 32'(fe_cnt - fe0), 32'd0);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 1'b1);
    idle(2);
    chk("lowrst_next_frame", 32'(exp_q.size()), 32'd0);

`ifdef UART_RX_PARITY_EN
    // bad parity: no word, one par_err pulse; then good parity delivers 0x07
    pe0 = pe_cnt;
    rise_cyc = -1;
    send_frame(8'h07, 1'b1, 1'b0);
    idle(2);
    chk("par_bad_pulse", 32'(pe_cnt - pe0), 32'd1);
    chk("par_bad_no_word", 32'(rise_cyc), 32'hFFFF_FFFF);
    pe0 = pe_cnt;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(2);
    chk("par_good_pulse", 32'(pe_cnt - pe0), 32'd0);
    chk("par_good_word", 32'(exp_q.size()), 32'd0);
`endif

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
